// File: rtl/sort_engine.sv
// In-place bubble-sort engine over an on-chip word array with a host load/inspect port.
// One compare-and-swap per SCAN cycle; the array itself is never reset.
module sort_engine #(
    parameter int DW     = 16,
    parameter int AW     = 8,
    parameter int CW     = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic          CLK100MHZ,
    input  logic          rstn,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          we,
    output logic [DW-1:0] rdata,
    input  logic [AW:0]   len,
    input  logic          desc,
    input  logic          run,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt
);
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0]    ST_IDLE = 2'd0;
    localparam logic [1:0]    ST_SCAN = 2'd1;
    localparam logic [1:0]    ST_FIN  = 2'd2;
    localparam logic [AW:0]   DEPTH_V = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   LEN_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_A   = AW'(1'b1);
    localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    function automatic logic out_of_order(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic dsc);
        logic gt;
        logic lt;
        if (SIGNED) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return dsc ? lt : gt;
    endfunction

    logic [DW-1:0] r_mem [0:DEPTH-1];
    logic [1:0]    r_state;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] r_lim;
    logic          r_swp;
    logic          r_desc;
    logic          r_busy;
    logic          r_done;
    logic [CW-1:0] r_cnt;

    logic [AW:0]   w_len_clamp;
    logic [AW-1:0] w_idx_nx;
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic          w_swap;
    logic          w_last;
    logic          w_stop;

    assign w_idx_nx = r_idx + ONE_A;
    assign w_a      = r_mem[r_idx];
    assign w_b      = r_mem[w_idx_nx];
    assign w_swap   = (r_state == ST_SCAN) && out_of_order(w_a, w_b, r_desc);
    assign w_last   = (r_idx == (r_lim - ONE_A));
    // A pass ends the sort when nothing moved, counting a swap made on its final comparison.
    assign w_stop   = !(r_swp || w_swap) || (r_lim == ONE_A);

    assign rdata = r_mem[addr];
    assign busy  = r_busy;
    assign done  = r_done;
    assign cnt   = r_cnt;

    // Clamp the requested length to the array depth.
    always_comb begin
        if (len > DEPTH_V) begin
            w_len_clamp = DEPTH_V;
        end else begin
            w_len_clamp = len;
        end
    end

    // Array storage: host writes while idle, compare-and-swap while scanning.
    always_ff @(posedge CLK100MHZ) begin
        if ((r_state == ST_IDLE) && we) begin
            r_mem[addr] <= wdata;
        end else if (w_swap) begin
            r_mem[r_idx]    <= w_b;
            r_mem[w_idx_nx] <= w_a;
        end
    end

    // Sequencer: run acceptance, pass/index bookkeeping, cycle counter and status flags.
    always_ff @(posedge CLK100MHZ or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_idx   <= {AW{1'b0}};
            r_lim   <= {AW{1'b0}};
            r_swp   <= 1'b0;
            r_desc  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= {CW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_desc <= desc;
                        r_cnt  <= {CW{1'b0}};
                        r_idx  <= {AW{1'b0}};
                        r_swp  <= 1'b0;
                        // Low bits wrap correctly for L == DEPTH (all ones = DEPTH-1).
                        r_lim  <= w_len_clamp[AW-1:0] - ONE_A;
                        if (w_len_clamp <= LEN_ONE) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_SCAN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + ONE_C;
                    end
                    if (w_last) begin
                        if (w_stop) begin
                            r_state <= ST_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_lim <= r_lim - ONE_A;
                            r_idx <= {AW{1'b0}};
                            r_swp <= 1'b0;
                        end
                    end else begin
                        r_idx <= w_idx_nx;
                        r_swp <= r_swp | w_swap;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sort_engine.sv
// Bench for sort_engine: an unsigned and a signed instance share one stimulus stream and are
// checked every cycle against a reference that replays a textbook bubble sort.
module tb_sort_engine;
    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic        we;
    logic [2:0]  len;
    logic        desc;
    logic        run;
    logic [15:0] rdata0, rdata1;
    logic        busy0, busy1, done0, done1;
    logic [15:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    // Reference state, index 0 = unsigned instance, 1 = signed instance.
    logic [15:0] mm [2][4];
    logic [15:0] tr [2][8][4];
    int          trn [2];
    int          m_left [2];
    int          m_pos [2];
    int          m_cnt [2];
    bit          m_fin [2];
    bit          m_vld [4];

    always #5 clk = ~clk;

    sort_engine #(.DW(16), .AW(2), .CW(16), .SIGNED(1'b0)) u_dut0 (
        .CLK100MHZ(clk), .rstn(rstn), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata0),
        .len(len), .desc(desc), .run(run), .busy(busy0), .done(done0), .cnt(cnt0));

    sort_engine #(.DW(16), .AW(2), .CW(16), .SIGNED(1'b1)) u_dut1 (
        .CLK100MHZ(clk), .rstn(rstn), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata1),
        .len(len), .desc(desc), .run(run), .busy(busy1), .done(done1), .cnt(cnt1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit ooo(input logic [15:0] a, input logic [15:0] b, input bit dsc,
                               input bit sgn);
        int ia;
        int ib;
        if (sgn) begin
            ia = $signed(a);
            ib = $signed(b);
        end else begin
            ia = a;
            ib = b;
        end
        return dsc ? (ia < ib) : (ia > ib);
    endfunction

    // Plain bubble sort with early exit; records the array after every comparison.
    task automatic build(input int s, input int l, input bit dsc);
        logic [15:0] w [4];
        logic [15:0] t;
        bit sw;
        for (int j = 0; j < 4; j++) w[j] = mm[s][j];
        trn[s] = 0;
        for (int lim = l - 1; lim >= 1; lim--) begin
            sw = 1'b0;
            for (int i = 0; i < lim; i++) begin
                if (ooo(w[i], w[i+1], dsc, s == 1)) begin
                    t = w[i]; w[i] = w[i+1]; w[i+1] = t; sw = 1'b1;
                end
                for (int j = 0; j < 4; j++) tr[s][trn[s]][j] = w[j];
                trn[s]++;
            end
            if (!sw) break;
        end
    endtask

    // Reference model advanced on every clock edge.
    initial begin
        for (int s = 0; s < 2; s++) begin
            m_left[s] = 0; m_pos[s] = 0; m_cnt[s] = 0; m_fin[s] = 1'b0; trn[s] = 0;
            for (int j = 0; j < 4; j++) mm[s][j] = 16'd0;
        end
        for (int j = 0; j < 4; j++) m_vld[j] = 1'b0;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                for (int s = 0; s < 2; s++) begin
                    m_left[s] = 0; m_pos[s] = 0; m_cnt[s] = 0; m_fin[s] = 1'b0;
                end
            end else begin
                for (int s = 0; s < 2; s++) begin
                    if (m_left[s] > 0) begin
                        for (int j = 0; j < 4; j++) mm[s][j] = tr[s][m_pos[s]][j];
                        m_pos[s]++; m_left[s]--; m_cnt[s]++;
                        if (m_left[s] == 0) m_fin[s] = 1'b1;
                    end else if (m_fin[s]) begin
                        m_fin[s] = 1'b0;
                    end else begin
                        if (we) begin
                            mm[s][addr] = wdata;
                            m_vld[addr] = 1'b1;
                        end
                        if (run) begin
                            build(s, (len > 3'd4) ? 4 : int'(len), desc);
                            m_cnt[s] = 0; m_pos[s] = 0; m_left[s] = trn[s];
                            if (trn[s] == 0) m_fin[s] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the reference.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("busy0", 32'(busy0), 32'(m_left[0] > 0));
            chk("busy1", 32'(busy1), 32'(m_left[1] > 0));
            chk("done0", 32'(done0), 32'(m_fin[0]));
            chk("done1", 32'(done1), 32'(m_fin[1]));
            chk("cnt0", 32'(cnt0), m_cnt[0]);
            chk("cnt1", 32'(cnt1), m_cnt[1]);
            if (m_vld[addr]) begin
                chk("rdata0", 32'(rdata0), 32'(mm[0][addr]));
                chk("rdata1", 32'(rdata1), 32'(mm[1][addr]));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load(input logic [15:0] v0, input logic [15:0] v1,
                        input logic [15:0] v2, input logic [15:0] v3);
        logic [15:0] v [4];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        for (int j = 0; j < 4; j++) begin
            addr = 2'(j); wdata = v[j]; we = 1'b1;
            step();
        end
        we = 1'b0;
    endtask

    task automatic start(input int l, input bit d);
        len = 3'(l); desc = d; run = 1'b1;
        step();
        run = 1'b0;
    endtask

    task automatic wait_idle(output int nb, output int nd);
        bit ok;
        ok = 1'b0; nb = 0; nd = 0;
        for (int c = 0; c < 100; c++) begin
            if (busy0) nb++;
            if (done0) nd++;
            if (!busy0 && !busy1 && !done0 && !done1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_idle: still busy after 100 cycles at %0t", $time);
        end
    endtask

    task automatic rd4(input string nm, input bit s, input logic [15:0] e0, input logic [15:0] e1,
                       input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int j = 0; j < 4; j++) begin
            addr = 2'(j);
            #1;
            chk(nm, 32'(s ? rdata1 : rdata0), 32'(e[j]));
            step();
        end
    endtask

    initial begin
        int nb;
        int nd;
        int nk;
        rstn = 1'b0; addr = 2'd0; wdata = 16'd0; we = 1'b0; len = 3'd0; desc = 1'b0; run = 1'b0;
        repeat (3) step();
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        rstn = 1'b1;
        step();

        load(16'd3, 16'd1, 16'd2, 16'd0); start(4, 1'b0); wait_idle(nb, nd);
        chk("asc_busy_cycles", nb, 6); chk("asc_done_pulses", nd, 1);
        chk("asc_cnt", 32'(cnt0), 32'd6);
        rd4("asc_mem", 1'b0, 16'd0, 16'd1, 16'd2, 16'd3);

        load(16'd3, 16'd1, 16'd2, 16'd0); start(4, 1'b1); wait_idle(nb, nd);
        chk("desc_busy_cycles", nb, 5); chk("desc_cnt", 32'(cnt0), 32'd5);
        rd4("desc_mem", 1'b0, 16'd3, 16'd2, 16'd1, 16'd0);

        load(16'd0, 16'd1, 16'd2, 16'd3); start(4, 1'b0); wait_idle(nb, nd);
        chk("sorted_cnt", 32'(cnt0), 32'd3); chk("sorted_busy_cycles", nb, 3);
        rd4("sorted_mem", 1'b0, 16'd0, 16'd1, 16'd2, 16'd3);

        load(16'd3, 16'd1, 16'd2, 16'd0);
        for (int l = 0; l < 2; l++) begin
            start(l, 1'b0);
            chk("short_done_next", 32'(done0), 32'd1);
            wait_idle(nb, nd);
            chk("short_busy_cycles", nb, 0); chk("short_cnt", 32'(cnt0), 32'd0);
        end
        rd4("short_mem", 1'b0, 16'd3, 16'd1, 16'd2, 16'd0);

        start(7, 1'b0); wait_idle(nb, nd);
        chk("clamp_cnt", 32'(cnt0), 32'd6);
        rd4("clamp_mem", 1'b0, 16'd0, 16'd1, 16'd2, 16'd3);

        load(16'h0001, 16'hFFFF, 16'd0, 16'd0); start(2, 1'b0); wait_idle(nb, nd);
        chk("sgn_cnt1", 32'(cnt1), 32'd1); chk("uns_cnt0", 32'(cnt0), 32'd1);
        rd4("sgn_mem", 1'b1, 16'hFFFF, 16'h0001, 16'd0, 16'd0);
        rd4("uns_mem", 1'b0, 16'h0001, 16'hFFFF, 16'd0, 16'd0);

        load(16'd3, 16'd1, 16'd2, 16'd0); start(4, 1'b0); step();
        addr = 2'd0; wdata = 16'd9; we = 1'b1; run = 1'b1; len = 3'd1; desc = 1'b1;
        step();
        we = 1'b0; run = 1'b0;
        wait_idle(nb, nd);
        chk("ignore_cnt", 32'(cnt0), 32'd6);
        rd4("ignore_mem", 1'b0, 16'd0, 16'd1, 16'd2, 16'd3);

        load(16'd3, 16'd1, 16'd2, 16'd0); start(4, 1'b0); step(); step();
        rstn = 1'b0;
        #1;
        chk("abort_busy", 32'(busy0), 32'd0); chk("abort_cnt", 32'(cnt0), 32'd0);
        step(); rstn = 1'b1; step();
        rd4("abort_mem", 1'b0, 16'd1, 16'd2, 16'd3, 16'd0);
        start(4, 1'b0); wait_idle(nb, nd);
        chk("resort_cnt", 32'(cnt0), 32'd6);
        rd4("resort_mem", 1'b0, 16'd0, 16'd1, 16'd2, 16'd3);

        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 1) == 0)
                load(16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)),
                     16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)));
            else
                load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            start($urandom_range(0, 7), 1'($urandom_range(0, 1)));
            nk = $urandom_range(0, 4);
            for (int k = 0; k < nk; k++) begin
                addr = 2'($urandom); wdata = 16'($urandom); we = 1'($urandom);
                run = 1'($urandom); len = 3'($urandom); desc = 1'($urandom);
                step();
            end
            we = 1'b0; run = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                rstn = 1'b0; step(); rstn = 1'b1;
            end
            addr = 2'($urandom);
            wait_idle(nb, nd);
            step();
        end

        for (int h = 0; h < 3; h++) begin
            load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            len = 3'd4; desc = 1'($urandom); run = 1'b1;
            for (int k = 0; k < 30; k++) begin
                addr = 2'($urandom);
                step();
            end
            run = 1'b0;
            wait_idle(nb, nd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
